// File: rtl/uartm_tx.sv
// uartm_tx : UART-master transmit engine (return path of the UART-master bridge).
//
// Serializes one 8/16/32-bit word per frame, LSB first:
//   start(0), W data bits, optional parity, stop(1).
// The frame configuration (width, parity enable, bit period) is latched when
// the word is accepted, so register writes during a frame do not affect it.
//
// Ports:
//   hclk, hresetn  clock, asynchronous active-low reset
//   uartm_baud     bit period minus 1, in hclk cycles
//   uartm_ctl      [1:0] width (00=8,01=16,10=32,11=8), [2] parity en, [3] 1=even 0=odd
//   tx_data        word to send (upper bits beyond width ignored)
//   tx_valid       tx_data valid
//   tx_ready       engine idle, will accept a word on this edge
//   TX             serial line, idle high
//   tx_busy        frame in progress (start through stop)
//   tx_done        one-cycle pulse when the frame has completed
//
// Build option: define UARTM_TX_TWO_STOP_EN for two stop bits per frame.

module uartm_tx #(
  parameter int BAUD_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic [BAUD_W-1:0] uartm_baud,
  input  logic [31:0]       uartm_ctl,
  input  logic [31:0]       tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              TX,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  logic [2:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] sh_baud;
  logic [2:0]        sh_ctl;    // width + parity enable; parity sense is folded into par_bit
  logic [4:0]        bit_cnt;
  logic [31:0]       shreg;
  logic              par_bit;
  logic              wrap;
  logic [4:0]        last_bit;
  logic              acc_par;
`ifdef UARTM_TX_TWO_STOP_EN
  logic              stop_cnt;
`endif

  // Upper control bits are reserved for other parts of the bridge.
  logic unused_ctl;
  assign unused_ctl = ^uartm_ctl[31:4];

  assign wrap = (baud_cnt == sh_baud);

  always_comb begin
    last_bit = 5'd7;
    case (sh_ctl[1:0])
      2'b01:   last_bit = 5'd15;
      2'b10:   last_bit = 5'd31;
      default: last_bit = 5'd7;
    endcase
  end

  // Parity is resolved from the incoming word at accept time, over only the
  // bits that will actually be transmitted.
  always_comb begin
    acc_par = ^tx_data[7:0];
    case (uartm_ctl[1:0])
      2'b01:   acc_par = ^tx_data[15:0];
      2'b10:   acc_par = ^tx_data;
      default: acc_par = ^tx_data[7:0];
    endcase
    if (!uartm_ctl[3]) acc_par = ~acc_par;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      sh_baud  <= '0;
      sh_ctl   <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      TX       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UARTM_TX_TWO_STOP_EN
      stop_cnt <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (state != TX_IDLE)
        baud_cnt <= wrap ? '0 : baud_cnt + 1'b1;

      case (state)
        TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            state    <= TX_START;
            shreg    <= tx_data;
            sh_ctl   <= uartm_ctl[2:0];
            sh_baud  <= uartm_baud;
            par_bit  <= acc_par;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            TX       <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
`ifdef UARTM_TX_TWO_STOP_EN
            stop_cnt <= 1'b0;
`endif
          end
        end
        TX_START: begin
          if (wrap) begin
            state   <= TX_DATA;
            TX      <= shreg[0];
            shreg   <= {1'b0, shreg[31:1]};
            bit_cnt <= '0;
          end
        end
        TX_DATA: begin
          if (wrap) begin
            if (bit_cnt == last_bit) begin
              if (sh_ctl[2]) begin
                state <= TX_PARITY;
                TX    <= par_bit;
              end else begin
                state <= TX_STOP;
                TX    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              TX      <= shreg[0];
              shreg   <= {1'b0, shreg[31:1]};
            end
          end
        end
        TX_PARITY: begin
          if (wrap) begin
            state <= TX_STOP;
            TX    <= 1'b1;
          end
        end
        TX_STOP: begin
          if (wrap) begin
`ifdef UARTM_TX_TWO_STOP_EN
            if (!stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              state    <= TX_IDLE;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
            end
`else
            state    <= TX_IDLE;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
`endif
          end
        end
        default: begin
          state    <= TX_IDLE;
          baud_cnt <= '0;
          TX       <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uartm_tx.sv
module tb_uartm_tx;

  logic        hclk;
  logic        hresetn;
  logic [31:0] uartm_baud;
  logic [31:0] uartm_ctl;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        TX;
  logic        tx_busy;
  logic        tx_done;

  int checks;
  int failures;

  uartm_tx #(.BAUD_W(32)) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .uartm_baud (uartm_baud),
    .uartm_ctl  (uartm_ctl),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .TX         (TX),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // exp: frame bits, bit k = line level during bit period k (start first).
  typedef struct {
    logic [31:0] baud;
    logic [31:0] ctl;
    logic [31:0] data;
    logic [36:0] exp;
    int          nbits;
    bit          chg;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge hclk);
    while (!tx_ready && n < 500) begin
      @(negedge hclk);
      n++;
    end
    if (!tx_ready) begin
      checks++;
      failures++;
      $display("FAIL wait_ready: tx_ready still %0b after %0d cycles", tx_ready, n);
    end
  endtask

  // Starts just after the accept edge; ends on the sample after the frame-end edge.
  task automatic check_frame(input logic [36:0] exp_in, input int nbits_in, input int p, input bit chg);
    logic [36:0] exp;
    int nb;
    int total;
    exp = exp_in;
    nb  = nbits_in;
`ifdef UARTM_TX_TWO_STOP_EN
    exp = exp | (37'd1 << nb);
    nb  = nb + 1;
`endif
    total = nb * p;
    for (int k = 0; k < total; k++) begin
      @(negedge hclk);
      chk($sformatf("tx_bit k=%0d", k), {63'd0, TX}, {63'd0, exp[k / p]});
      chk($sformatf("busy_status k=%0d", k), {61'd0, tx_busy, tx_ready, tx_done}, 64'h4);
      if (chg && k == 3) begin
        uartm_ctl  = 32'h0;
        uartm_baud = 32'd9;
      end
    end
    @(negedge hclk);
    chk("frame_end_status", {61'd0, tx_busy, tx_ready, tx_done}, 64'h3);
    chk("frame_end_tx", {63'd0, TX}, 64'h1);
  endtask

  task automatic send(input logic [31:0] baud, input logic [31:0] ctl, input logic [31:0] data,
                      input logic [36:0] exp, input int nbits, input bit chg);
    wait_ready();
    uartm_baud = baud;
    uartm_ctl  = ctl;
    tx_data    = data;
    tx_valid   = 1'b1;
    @(posedge hclk);
    #1 tx_valid = 1'b0;
    check_frame(exp, nbits, int'(baud) + 1, chg);
    @(negedge hclk);
    chk("post_done_status", {61'd0, tx_busy, tx_ready, tx_done}, 64'h2);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    hresetn    = 1'b0;
    uartm_baud = 32'd0;
    uartm_ctl  = 32'd0;
    tx_data    = 32'd0;
    tx_valid   = 1'b0;

    vecs[0] = '{32'd3, 32'h0, 32'h000000A5, 37'h00000034A, 10, 1'b0};
    vecs[1] = '{32'd0, 32'hD, 32'h00000001, 37'h000060002, 19, 1'b0};
    vecs[2] = '{32'd0, 32'h5, 32'h00000001, 37'h000040002, 19, 1'b0};
    vecs[3] = '{32'd1, 32'h2, 32'hFFFF0000, 37'h3FFFE0000, 34, 1'b1};
    vecs[4] = '{32'd1, 32'h3, 32'hFFFFFF00, 37'h000000200, 10, 1'b0};
    vecs[5] = '{32'd2, 32'h4, 32'h00000003, 37'h000000606, 11, 1'b0};
    vecs[6] = '{32'd0, 32'hE, 32'h80000001, 37'h500000002, 35, 1'b0};

    #12;
    chk("reset_tx", {63'd0, TX}, 64'h1);
    chk("reset_status", {61'd0, tx_busy, tx_ready, tx_done}, 64'h2);
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    chk("idle_status", {61'd0, tx_busy, tx_ready, tx_done}, 64'h2);

    for (int i = 0; i < 7; i++)
      send(vecs[i].baud, vecs[i].ctl, vecs[i].data, vecs[i].exp, vecs[i].nbits, vecs[i].chg);

    // Back-to-back with tx_valid held high: second word accepted on the edge
    // after tx_done, one idle-high cycle between frames.
    wait_ready();
    uartm_baud = 32'd0;
    uartm_ctl  = 32'h0;
    tx_data    = 32'h00000055;
    tx_valid   = 1'b1;
    @(posedge hclk);
    #1 tx_data = 32'h0000000F;
    // 0x55: frame 0,1,0,1,0,1,0,1,0,1
    check_frame(37'h2AA, 10, 1, 1'b0);
    @(posedge hclk);
    #1 tx_valid = 1'b0;
    // 0x0F: frame 0,1,1,1,1,0,0,0,0,1
    check_frame(37'h21E, 10, 1, 1'b0);
    @(negedge hclk);
    chk("b2b_post_status", {61'd0, tx_busy, tx_ready, tx_done}, 64'h2);

    // Reset during data bits: line returns high immediately, no tx_done.
    wait_ready();
    uartm_baud = 32'd3;
    uartm_ctl  = 32'h0;
    tx_data    = 32'h000000A5;
    tx_valid   = 1'b1;
    @(posedge hclk);
    #1 tx_valid = 1'b0;
    repeat (9) @(negedge hclk);
    chk("pre_reset_busy", {63'd0, tx_busy}, 64'h1);
    hresetn = 1'b0;
    #1;
    chk("async_reset_tx", {63'd0, TX}, 64'h1);
    chk("async_reset_status", {61'd0, tx_busy, tx_ready, tx_done}, 64'h2);
    repeat (2) begin
      @(negedge hclk);
      chk("in_reset_no_done", {63'd0, tx_done}, 64'h0);
    end
    hresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      chk("after_reset_no_done", {62'd0, tx_done, TX}, 64'h1);
    end
    send(vecs[0].baud, vecs[0].ctl, vecs[0].data, vecs[0].exp, vecs[0].nbits, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
